// File: rtl/reg_drain_if.sv
// Write-strobe capture and drain handshake bundle for reg_drain.
// The master modport is the buffer itself. The slave modport is the producer/consumer side.
interface reg_drain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             ena;
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    input  ena, data, out_ready, clr_ovf,
    output out_valid, out, count, overflow
  );

  modport slave (
    output ena, data, out_ready, clr_ovf,
    input  out_valid, out, count, overflow
  );
endinterface

// File: rtl/reg_drain.sv
// Buffers ena-strobed words (DEPTH deep, in order) and hands them out over valid/ready; 1-cycle write-to-visible latency.
// The producer never stalls: a write into a full buffer with no pop is dropped and sets sticky overflow. All outputs are registered.
module reg_drain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic       clock,
  input logic       reset,
  reg_drain_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_inc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             vld;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nxt;
  logic             load_head;
  logic             ovf;
  logic             push;
  logic             pop;
  logic             drop;

  assign pop    = vld & bus.out_ready;
  assign push   = bus.ena & ((cnt != FULL) | pop);
  assign drop   = bus.ena & (cnt == FULL) & ~pop;
  assign rd_inc = rd_ptr + 1'b1;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + ONE;
      2'b01:   cnt_nxt = cnt - ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  // The head register mirrors mem[rd_ptr]; a word pushed into an empty
  // (or just-emptying) buffer goes straight to the head.
  always_comb begin
    load_head = 1'b0;
    head_nxt  = head;
    if (push && (cnt == '0 || (pop && cnt == ONE))) begin
      load_head = 1'b1;
      head_nxt  = bus.data;
    end else if (pop && cnt > ONE) begin
      load_head = 1'b1;
      head_nxt  = mem[rd_inc];
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem[wr_ptr] <= bus.data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      head   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_inc;
      end
      cnt <= cnt_nxt;
      vld <= (cnt_nxt != '0);
      if (load_head) begin
        head <= head_nxt;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld;
  assign bus.out       = head;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_reg_drain.sv
// Directed bench for reg_drain (WIDTH=32, DEPTH=4): inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_drain;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  reg_drain_if #(.WIDTH(32), .DEPTH(4)) bus ();

  reg_drain #(.WIDTH(32), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ena       = 1'b0;
    bus.data      = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.ena       = 1'b1;
    bus.data      = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    bus.clr_ovf   = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 32'h0 || bus.count !== 3'd0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got vld=%b out=%h cnt=%0d ovf=%b expected 0 0 0 0",
               bus.out_valid, bus.out, bus.count, bus.overflow);
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: got vld=%b cnt=%0d expected 0 0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.ena  = 1'b1;
    bus.data = 32'hA5A5_0001;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'hA5A5_0001 || bus.count !== 3'd1) begin
      failures++;
      $display("FAIL single_push: got vld=%b out=%h cnt=%0d expected 1 a5a50001 1",
               bus.out_valid, bus.out, bus.count);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL single_hold: got vld=%b out=%h expected 1 a5a50001", bus.out_valid, bus.out);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.out !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL single_pop: got vld=%b cnt=%0d out=%h expected 0 0 a5a50001",
               bus.out_valid, bus.count, bus.out);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.ena  = 1'b1;
      bus.data = i;
      tick();
    end
    bus.ena = 1'b0;
    checks++;
    if (bus.count !== 3'd4 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_overflow: got cnt=%0d ovf=%b expected 4 1", bus.count, bus.overflow);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== k) begin
        failures++;
        $display("FAIL fill_drain[%0d]: got vld=%b out=%h expected 1 %h", k, bus.out_valid, bus.out, k);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_empty: got vld=%b cnt=%0d ovf=%b expected 0 0 1",
               bus.out_valid, bus.count, bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd2;
    exp_v[1] = 32'd3;
    exp_v[2] = 32'd4;
    exp_v[3] = 32'd9;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.ena  = 1'b1;
      bus.data = i;
      tick();
    end
    bus.data      = 32'd9;
    bus.out_ready = 1'b1;
    tick();
    bus.ena       = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 3'd4 || bus.overflow !== 1'b0 || bus.out !== 32'd2) begin
      failures++;
      $display("FAIL full_push_pop: got cnt=%0d ovf=%b out=%h expected 4 0 2",
               bus.count, bus.overflow, bus.out);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp_v[k]) begin
        failures++;
        $display("FAIL full_drain[%0d]: got vld=%b out=%h expected 1 %h", k, bus.out_valid, bus.out, exp_v[k]);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 3'd0) begin
      failures++;
      $display("FAIL full_empty: got cnt=%0d expected 0", bus.count);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.ena  = 1'b1;
      bus.data = i;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== i || bus.count !== 3'd1 || bus.overflow !== 1'b0) begin
        failures++;
        $display("FAIL stream[%0d]: got vld=%b out=%h cnt=%0d ovf=%b expected 1 %h 1 0",
                 i, bus.out_valid, bus.out, bus.count, bus.overflow, i);
      end
    end
    bus.ena = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.out !== 32'd99) begin
      failures++;
      $display("FAIL stream_end: got vld=%b cnt=%0d out=%h expected 0 0 63",
               bus.out_valid, bus.count, bus.out);
    end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.ena  = 1'b1;
      bus.data = 32'h100 + i;
      tick();
    end
    bus.data    = 32'h1FF;
    bus.clr_ovf = 1'b1;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4 || bus.out !== 32'h101) begin
      failures++;
      $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d out=%h expected 1 4 101",
               bus.overflow, bus.count, bus.out);
    end
    tick();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0 || bus.count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%b cnt=%0d expected 0 4", bus.overflow, bus.count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.ena  = 1'b1;
      bus.data = 32'h200 + i;
      tick();
    end
    bus.ena       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 3'd3 || bus.overflow !== 1'b1 || bus.out !== 32'h202) begin
      failures++;
      $display("FAIL mid_setup: got cnt=%0d ovf=%b out=%h expected 3 1 202", bus.count, bus.overflow, bus.out);
    end
    reset    = 1'b0;
    bus.ena  = 1'b1;
    bus.data = 32'h0000_0077;
    tick();
    reset   = 1'b1;
    bus.ena = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out !== 32'h0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got cnt=%0d vld=%b out=%h ovf=%b expected 0 0 0 0",
               bus.count, bus.out_valid, bus.out, bus.overflow);
    end
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_not_stored: got cnt=%0d vld=%b expected 0 0", bus.count, bus.out_valid);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_streaming();
    test_ovf_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_drain.md
# reg_drain

Read-side counterpart to the crossbar's enable-loaded registers: captures each word written with an `ena` strobe and hands it to a downstream consumer over a valid/ready handshake. The producer side cannot be stalled, so the block buffers up to DEPTH words in order. When the buffer is full it drops the incoming word and raises a sticky overflow flag. It sits at each crossbar output port, between the port's write strobe and the egress logic.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 4: buffer capacity in words; power of two, ≥2.
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of `clock`.
- ena  input  1  write strobe; `data` is offered on every cycle it is high.
- data  input  WIDTH  write data, qualified by `ena`.
- out_valid  output  1  head word present on `out`.
- out_ready  input  1  consumer accepts head when high together with `out_valid`.
- out  output  WIDTH  head word, driven from a register.
- count  output  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- overflow  output  1  sticky; set when a word is dropped.
- clr_ovf  input  1  clears `overflow`.

## Operation
- Reset (reset=0 at an edge): `out_valid`=0, `out`=0, `count`=0, `overflow`=0. All buffered words are discarded. `ena`, `out_ready` and `clr_ovf` are ignored during reset.
- Push: `ena`=1 and (count<DEPTH, or a pop occurs in the same cycle). The word is appended at the tail.
- Pop: `out_valid`=1 and `out_ready`=1. The head is removed, and the next word, if any, becomes the head.
- Drop: `ena`=1, count=DEPTH and no pop in the same cycle. The word is discarded and `overflow` is set; `count` and contents are unchanged.
- Push and pop in the same cycle: `count` is unchanged. When count=1, the pushed word becomes the new head.
- Ordering is strict FIFO. No word is duplicated, reordered or lost except by a drop.
- `out_valid` = (count≠0), registered.
- When empty, `out` holds the last popped word (0 after reset). Consumers must qualify `out` with `out_valid`.
- `out_valid`, once high, stays high with `out` stable until a pop occurs.
- `count` arithmetic: next = count + push − pop. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- `overflow`: set on a drop and cleared by `clr_ovf`. When a drop and `clr_ovf` occur in the same cycle, set wins.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Write-to-visible latency is 1 cycle. With `ena` at edge N into an empty buffer, `out_valid`=1 and `out`=data after edge N; there is no same-cycle bypass.
- Pop at edge N: the next head appears on `out` after edge N. Back-to-back pops sustain 1 word/cycle.
- Steady push+pop every cycle sustains 1 word/cycle indefinitely with no drops.
- `count` and `overflow` update at the same edge as the push, pop or drop that causes them.
- `out_ready` has no combinational path to any output; all outputs are registers.

## Test plan
- Reset, then single word: push 0xA5A5_0001 at edge 1 with `out_ready`=0. Required after edge 1: `out_valid`=1, `out`=0xA5A5_0001, `count`=1. Raise `out_ready` at edge 3; required after it: `out_valid`=0, `count`=0, `out` still 0xA5A5_0001.
- Fill and overflow (DEPTH=4): push 1,2,3,4,5 on consecutive cycles with `out_ready`=0. Required: `count`=4, `overflow`=1 after the 5th edge. Then drain and read exactly 1,2,3,4.
- Full with simultaneous push+pop: at count=4, push 9 with `out_ready`=1. Required: no drop, `overflow` unchanged, `count`=4, and drain yields 2,3,4,9.
- Streaming: push 0..99 every cycle with `out_ready`=1 throughout. Required: the outputs are 0..99 in order, each one cycle after its push; `count` ≤1; `overflow`=0.
- Overflow clear priority: a drop and `clr_ovf`=1 in the same cycle leaves `overflow`=1. `clr_ovf` alone on the next cycle gives `overflow`=0.
- Reset mid-operation: with count=3 and `overflow`=1, assert `reset`=0 for one edge while `ena`=1. Required after that edge: `count`=0, `out_valid`=0, `out`=0, `overflow`=0, and the word offered during reset is not stored.
